// File: rtl/execute_shift_unit_pkg.sv
// Shared command codes, internal shift modes and FSM state encodings for the
// multi-cycle shift/rotate execution unit.
package execute_shift_unit_pkg;

  localparam int unsigned CMD_W = 5;

  localparam logic [CMD_W-1:0] EXE_SHIFT_BUFFER      = 5'h00;
  localparam logic [CMD_W-1:0] EXE_SHIFT_LOGICL      = 5'h01;
  localparam logic [CMD_W-1:0] EXE_SHIFT_LOGICR      = 5'h02;
  localparam logic [CMD_W-1:0] EXE_SHIFT_ALITHMETICR = 5'h03;
  localparam logic [CMD_W-1:0] EXE_SHIFT_ROTATEL     = 5'h04;
  localparam logic [CMD_W-1:0] EXE_SHIFT_ROTATER     = 5'h05;

  typedef enum logic [2:0] {
    EXE_SHIFT_MODE_BUF = 3'd0,
    EXE_SHIFT_MODE_LSL = 3'd1,
    EXE_SHIFT_MODE_LSR = 3'd2,
    EXE_SHIFT_MODE_ASR = 3'd3,
    EXE_SHIFT_MODE_ROL = 3'd4,
    EXE_SHIFT_MODE_ROR = 3'd5
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OUT   = 2'd2
  } shift_state_e;

endpackage

// File: rtl/execute_shift_unit_step.sv
// Combinational single-step shifter: moves data by k (<= STEP_N) positions in
// the given mode and reports the last bit moved out.
module execute_shift_unit_step
  import execute_shift_unit_pkg::*;
#(
  parameter int unsigned DATA_N = 32,
  parameter int unsigned STEP_N = 8,
  parameter int unsigned K_N    = $clog2(STEP_N) + 1
) (
  input  logic [DATA_N-1:0] data,
  input  shift_mode_e       mode,
  input  logic [K_N-1:0]    k,
  output logic [DATA_N-1:0] shifted_c,
  output logic              carry_c
);

  logic [DATA_N:0]     lsl_w;
  logic [DATA_N:0]     lsr_w;
  logic [DATA_N:0]     asr_w;
  logic [2*DATA_N-1:0] dd;

  // Extra bit beside the operand catches the final bit shifted out.
  always_comb begin
    dd        = {data, data};
    lsl_w     = {1'b0, data} << k;
    lsr_w     = {data, 1'b0} >> k;
    asr_w     = $signed({data, 1'b0}) >>> k;
    shifted_c = data;
    carry_c   = 1'b0;
    case (mode)
      EXE_SHIFT_MODE_LSL: begin
        shifted_c = lsl_w[DATA_N-1:0];
        carry_c   = lsl_w[DATA_N];
      end
      EXE_SHIFT_MODE_LSR: begin
        shifted_c = lsr_w[DATA_N:1];
        carry_c   = lsr_w[0];
      end
      EXE_SHIFT_MODE_ASR: begin
        shifted_c = asr_w[DATA_N:1];
        carry_c   = asr_w[0];
      end
      EXE_SHIFT_MODE_ROL: begin
        shifted_c = DATA_N'(dd >> (DATA_N - 32'(k)));
        carry_c   = shifted_c[0];
      end
      EXE_SHIFT_MODE_ROR: begin
        shifted_c = DATA_N'(dd >> k);
        carry_c   = shifted_c[DATA_N-1];
      end
      default: ;
    endcase
    if (k == '0) carry_c = 1'b0;
  end

endmodule

// File: rtl/execute_shift_unit.sv
// Multi-cycle shift/rotate execution unit: shifts at most STEP_N positions per
// clock and returns data, carry and zero over a valid/busy handshake.
module execute_shift_unit
  import execute_shift_unit_pkg::*;
#(
  parameter int unsigned DATA_N = 32,
  parameter int unsigned STEP_N = 8,
  localparam int unsigned AMT_N = $clog2(DATA_N)
) (
  input  logic              iCLOCK,
  input  logic              iRESET_SYNC,
  input  logic              iFLUSH,
  input  logic              iREQ_VALID,
  output logic              oREQ_BUSY,
  input  logic [CMD_W-1:0]  iREQ_CMD,
  input  logic [DATA_N-1:0] iREQ_DATA,
  input  logic [AMT_N-1:0]  iREQ_AMT,
  output logic              oOUT_VALID,
  input  logic              iOUT_BUSY,
  output logic [DATA_N-1:0] oOUT_DATA,
  output logic              oOUT_CARRY,
  output logic              oOUT_ZERO
);

  localparam int unsigned K_N = $clog2(STEP_N) + 1;

  function automatic shift_mode_e decode_cmd(input logic [CMD_W-1:0] cmd);
    case (cmd)
      EXE_SHIFT_LOGICL:      return EXE_SHIFT_MODE_LSL;
      EXE_SHIFT_LOGICR:      return EXE_SHIFT_MODE_LSR;
      EXE_SHIFT_ALITHMETICR: return EXE_SHIFT_MODE_ASR;
      EXE_SHIFT_ROTATEL:     return EXE_SHIFT_MODE_ROL;
      EXE_SHIFT_ROTATER:     return EXE_SHIFT_MODE_ROR;
      default:               return EXE_SHIFT_MODE_BUF;
    endcase
  endfunction

  shift_state_e      state_q, state_d;
  shift_mode_e       mode_q, mode_d;
  logic [DATA_N-1:0] data_q, data_d;
  logic [AMT_N-1:0]  rem_q, rem_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [K_N-1:0]    k_c;
  logic [DATA_N-1:0] step_data_c;
  logic              step_carry_c;
  logic              accept_c;

  execute_shift_unit_step #(
    .DATA_N (DATA_N),
    .STEP_N (STEP_N),
    .K_N    (K_N)
  ) u_step (
    .data      (data_q),
    .mode      (mode_q),
    .k         (k_c),
    .shifted_c (step_data_c),
    .carry_c   (step_carry_c)
  );

  // Next-state and datapath update; flush abandons everything but held outputs.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    data_d   = data_q;
    rem_d    = rem_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    k_c      = (32'(rem_q) >= STEP_N) ? K_N'(STEP_N) : K_N'(rem_q);
    accept_c = iREQ_VALID & ~busy_q & ~iFLUSH;
    if (iFLUSH) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            mode_d  = decode_cmd(iREQ_CMD);
            data_d  = iREQ_DATA;
            rem_d   = iREQ_AMT;
            carry_d = 1'b0;
            if (mode_d == EXE_SHIFT_MODE_BUF || iREQ_AMT == '0) begin
              state_d = ST_OUT;
              rem_d   = '0;
              zero_d  = (iREQ_DATA == '0);
            end else begin
              state_d = ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_d  = step_data_c;
          carry_d = step_carry_c;
          rem_d   = rem_q - AMT_N'(k_c);
          if (rem_d == '0) begin
            state_d = ST_OUT;
            zero_d  = (step_data_c == '0);
          end
        end
        ST_OUT: begin
          if (!iOUT_BUSY) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q <= ST_IDLE;
      mode_q  <= EXE_SHIFT_MODE_BUF;
      data_q  <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign oREQ_BUSY  = busy_q;
  assign oOUT_VALID = valid_q;
  assign oOUT_DATA  = data_q;
  assign oOUT_CARRY = carry_q;
  assign oOUT_ZERO  = zero_q;

endmodule

// File: tb/tb_execute_shift_unit.sv
// Scoreboard bench for execute_shift_unit: directed commands push expected
// results; a forked monitor pops and compares whenever a result appears.
module tb_execute_shift_unit;

  localparam logic [4:0] C_BUF = 5'h00;
  localparam logic [4:0] C_LSL = 5'h01;
  localparam logic [4:0] C_LSR = 5'h02;
  localparam logic [4:0] C_ASR = 5'h03;
  localparam logic [4:0] C_ROL = 5'h04;
  localparam logic [4:0] C_ROR = 5'h05;

  logic        clk = 1'b0;
  logic        iRESET_SYNC = 1'b1;
  logic        iFLUSH = 1'b0;
  logic        iREQ_VALID = 1'b0;
  logic        oREQ_BUSY;
  logic [4:0]  iREQ_CMD = '0;
  logic [31:0] iREQ_DATA = '0;
  logic [4:0]  iREQ_AMT = '0;
  logic        oOUT_VALID;
  logic        iOUT_BUSY = 1'b0;
  logic [31:0] oOUT_DATA;
  logic        oOUT_CARRY;
  logic        oOUT_ZERO;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   valid_seen = 0;

  execute_shift_unit #(.DATA_N(32), .STEP_N(8)) dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (iRESET_SYNC),
    .iFLUSH      (iFLUSH),
    .iREQ_VALID  (iREQ_VALID),
    .oREQ_BUSY   (oREQ_BUSY),
    .iREQ_CMD    (iREQ_CMD),
    .iREQ_DATA   (iREQ_DATA),
    .iREQ_AMT    (iREQ_AMT),
    .oOUT_VALID  (oOUT_VALID),
    .iOUT_BUSY   (iOUT_BUSY),
    .oOUT_DATA   (oOUT_DATA),
    .oOUT_CARRY  (oOUT_CARRY),
    .oOUT_ZERO   (oOUT_ZERO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops one expectation per result; re-checks held outputs under back-pressure.
  task automatic monitor();
    logic shown = 1'b0;
    logic have = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (oOUT_VALID) begin
        if (!shown) begin
          shown = 1'b1;
          valid_seen++;
          if (exp_q.size() == 0) begin
            have = 1'b0;
            chk("unexpected_result", 32'(exp_q.size()), 1);
          end else begin
            have = 1'b1;
            e = exp_q.pop_front();
            chk("out_data", oOUT_DATA, e.data);
            chk("out_carry", 32'(oOUT_CARRY), 32'(e.carry));
            chk("out_zero", 32'(oOUT_ZERO), 32'(e.zero));
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          end
        end else if (have) begin
          chk("held_data", oOUT_DATA, e.data);
          chk("held_carry", 32'(oOUT_CARRY), 32'(e.carry));
          chk("held_zero", 32'(oOUT_ZERO), 32'(e.zero));
          chk("held_req_busy", 32'(oREQ_BUSY), 1);
        end
      end else begin
        shown = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [4:0] cmd, input logic [31:0] d, input logic [4:0] amt,
                       input logic [31:0] ed, input logic ec, input logic ez, input int lat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (oREQ_BUSY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (oREQ_BUSY) begin
      chk("issue_wait_busy", 32'(oREQ_BUSY), 0);
      return;
    end
    e.data = ed; e.carry = ec; e.zero = ez; e.lat = lat; e.acc = cyc + 1;
    exp_q.push_back(e);
    iREQ_VALID = 1'b1; iREQ_CMD = cmd; iREQ_DATA = d; iREQ_AMT = amt;
    @(negedge clk);
    iREQ_VALID = 1'b0;
    chk("accept_busy", 32'(oREQ_BUSY), 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || oREQ_BUSY) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 0);
    chk("drain_busy", 32'(oREQ_BUSY), 0);
  endtask

  // Start an amt-31 op and abort it in its second SHIFT cycle with a request pending.
  task automatic abort_op(input logic [31:0] d, input logic use_reset);
    int seen0;
    drain();
    @(negedge clk);
    iREQ_VALID = 1'b1; iREQ_CMD = C_LSL; iREQ_DATA = d; iREQ_AMT = 5'd31;
    @(negedge clk);
    iREQ_VALID = 1'b0;
    chk("abort_accept_busy", 32'(oREQ_BUSY), 1);
    @(negedge clk);
    iREQ_VALID = 1'b1; iREQ_CMD = C_BUF; iREQ_DATA = 32'hAAAA_5555; iREQ_AMT = 5'd0;
    if (use_reset) iRESET_SYNC = 1'b1; else iFLUSH = 1'b1;
    seen0 = valid_seen;
    @(negedge clk);
    iREQ_VALID = 1'b0; iRESET_SYNC = 1'b0; iFLUSH = 1'b0;
    chk("abort_busy", 32'(oREQ_BUSY), 0);
    chk("abort_valid", 32'(oOUT_VALID), 0);
    if (use_reset) begin
      chk("rst_data", oOUT_DATA, 0);
      chk("rst_carry", 32'(oOUT_CARRY), 0);
      chk("rst_zero", 32'(oOUT_ZERO), 0);
    end
    repeat (8) @(negedge clk);
    chk("abort_no_result", 32'(valid_seen), 32'(seen0));
    chk("abort_not_accepted", 32'(oREQ_BUSY), 0);
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(oREQ_BUSY), 0);
    chk("reset_valid", 32'(oOUT_VALID), 0);
    chk("reset_data", oOUT_DATA, 0);
    chk("reset_carry", 32'(oOUT_CARRY), 0);
    chk("reset_zero", 32'(oOUT_ZERO), 0);
    iRESET_SYNC = 1'b0;

    issue(C_LSL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 5);
    issue(C_ASR, 32'h8000_0010, 5'd4,  32'hF800_0001, 1'b0, 1'b0, 2);
    issue(C_LSR, 32'h0000_0018, 5'd4,  32'h0000_0001, 1'b1, 1'b0, 2);
    issue(C_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, 1'b0, 2);
    issue(C_ROL, 32'h8000_0000, 5'd9,  32'h0000_0100, 1'b0, 1'b0, 3);
    issue(C_LSL, 32'h0000_00F0, 5'd0,  32'h0000_00F0, 1'b0, 1'b0, 1);
    issue(5'h1F, 32'h1234_5678, 5'd7,  32'h1234_5678, 1'b0, 1'b0, 1);
    issue(C_LSR, 32'h0000_0001, 5'd4,  32'h0000_0000, 1'b0, 1'b1, 2);
    issue(C_LSL, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b1, 1'b0, 2);
    issue(C_ASR, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 5);
    issue(C_ROL, 32'h8000_0001, 5'd8,  32'h0000_0180, 1'b0, 1'b0, 2);
    issue(C_ROR, 32'h0000_00F0, 5'd16, 32'h00F0_0000, 1'b0, 1'b0, 3);
    drain();

    // Back-pressure: hold the result 3 cycles with a second request waiting.
    iOUT_BUSY = 1'b1;
    issue(C_LSL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 5);
    n = 0;
    while (!oOUT_VALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(oOUT_VALID), 1);
    iREQ_VALID = 1'b1; iREQ_CMD = C_ROR; iREQ_DATA = 32'h0000_0001; iREQ_AMT = 5'd1;
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(oOUT_VALID), 1);
      chk("bp_hold_busy", 32'(oREQ_BUSY), 1);
    end
    iOUT_BUSY = 1'b0;
    @(negedge clk);
    chk("bp_release_busy", 32'(oREQ_BUSY), 0);
    chk("bp_release_valid", 32'(oOUT_VALID), 0);
    begin
      exp_t e;
      e.data = 32'h8000_0000; e.carry = 1'b1; e.zero = 1'b0; e.lat = 2; e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    iREQ_VALID = 1'b0;
    chk("bp_second_accept", 32'(oREQ_BUSY), 1);
    drain();

    abort_op(32'h0000_0001, 1'b0);
    issue(C_BUF, 32'h0000_0000, 5'd5, 32'h0000_0000, 1'b0, 1'b1, 1);
    abort_op(32'hFFFF_FFFF, 1'b1);

    issue(C_LSR, 32'h0000_0018, 5'd4, 32'h0000_0001, 1'b1, 1'b0, 2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
